pcs_rx_decoder: RTL and testbench

PCS_RX_DECODER -- requirements
Module: pcs_rx_decoder

---
 rtl/pcs_rx_decoder_if.sv | 30 +++
 rtl/pcs_rx_decoder.sv | 150 +++++++++++++++
 tb/tb_pcs_rx_decoder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_rx_decoder_if.sv
// Bus bundle for the 257b/4x66b receive decoder: scrambled block in,
// recovered frames, error flag and error count out.
interface pcs_rx_decoder_if #(
    parameter int TRANSCODER_WIDTH = 257,
    parameter int FRAME_WIDTH      = 66,
    parameter int COUNT_WIDTH      = 32
);
    logic                        i_valid;
    logic [TRANSCODER_WIDTH-1:0] i_data;
    logic                        i_clr_count;
    logic                        o_valid;
    logic [FRAME_WIDTH-1:0]      o_frame_0;
    logic [FRAME_WIDTH-1:0]      o_frame_1;
    logic [FRAME_WIDTH-1:0]      o_frame_2;
    logic [FRAME_WIDTH-1:0]      o_frame_3;
    logic                        o_block_err;
    logic [COUNT_WIDTH-1:0]      o_err_count;

    modport master (
        output i_valid, i_data, i_clr_count,
        input  o_valid, o_frame_0, o_frame_1, o_frame_2, o_frame_3,
               o_block_err, o_err_count
    );

    modport slave (
        input  i_valid, i_data, i_clr_count,
        output o_valid, o_frame_0, o_frame_1, o_frame_2, o_frame_3,
               o_block_err, o_err_count
    );
endinterface

// File: rtl/pcs_rx_decoder.sv
// Receive path: self-synchronous x^58+x^39+1 descrambler followed by a
// 257b -> 4x 64b/66b transcode decoder with saturating block-error counter.
module pcs_rx_decoder #(
    parameter int TRANSCODER_WIDTH = 257,
    parameter int FRAME_WIDTH      = 66,
    parameter int COUNT_WIDTH      = 32
) (
    input logic                clk,
    input logic                i_rst_n,
    pcs_rx_decoder_if.slave    bus
);
    localparam int HIST_W = 58;
    localparam int EXT_W  = 512;
    localparam logic [FRAME_WIDTH-1:0] ERR_FRAME = {2'b10, {8{7'h1E}}, 8'h1E};

    function automatic logic [7:0] restore_type(input logic [3:0] nib);
        logic [7:0] t;
        case (nib)
            4'h1:    t = 8'hE1;
            4'h2:    t = 8'hD2;
            4'h3:    t = 8'h33;
            4'h4:    t = 8'hB4;
            4'h5:    t = 8'h55;
            4'h6:    t = 8'h66;
            4'h7:    t = 8'h87;
            4'h8:    t = 8'h78;
            4'h9:    t = 8'h99;
            4'hA:    t = 8'hAA;
            4'hB:    t = 8'h4B;
            4'hC:    t = 8'hCC;
            4'hD:    t = 8'h2D;
            4'hE:    t = 8'h1E;
            4'hF:    t = 8'hFF;
            default: t = 8'h00;
        endcase
        return t;
    endfunction

    logic [HIST_W-1:0]           hist_q, hist_d;
    logic                        primed_q, primed_d;
    logic                        vld_p1_q, vld_p1_d;
    logic [TRANSCODER_WIDTH-1:0] data_p1_q, data_p1_d;
    logic                        vld_p2_q, vld_p2_d;
    logic                        err_p2_q, err_p2_d;
    logic [FRAME_WIDTH-1:0]      frame_p2_q [4];
    logic [FRAME_WIDTH-1:0]      frame_p2_d [4];
    logic [COUNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic [TRANSCODER_WIDTH+HIST_W-1:0] scr_ext;
    logic [TRANSCODER_WIDTH-1:0]        desc;
    logic [EXT_W-1:0]                   d_ext;
    logic [3:0]                         mask;
    logic [3:0]                         nib;
    logic [8:0]                         pos;
    logic                               seen_ctl;
    logic                               dec_err;
    logic [FRAME_WIDTH-1:0]             dec_frame [4];

    // Stage 1: descramble. scr_ext[57] is the most recent prior scrambled bit,
    // so bit i of the block sits at scr_ext[i+58] and its taps at i+19 and i.
    always_comb begin
        scr_ext   = {bus.i_data, hist_q};
        desc      = scr_ext[TRANSCODER_WIDTH+HIST_W-1:HIST_W]
                  ^ scr_ext[TRANSCODER_WIDTH+HIST_W-40:HIST_W-39]
                  ^ scr_ext[TRANSCODER_WIDTH-1:0];
        hist_d    = hist_q;
        primed_d  = primed_q;
        vld_p1_d  = 1'b0;
        data_p1_d = data_p1_q;
        if (bus.i_valid) begin
            hist_d    = bus.i_data[TRANSCODER_WIDTH-1 -: HIST_W];
            primed_d  = 1'b1;
            vld_p1_d  = primed_q;
            data_p1_d = desc;
        end
    end

    // Stage 2: unpack. Fields are consumed in frame order from a running
    // bit pointer; the first control frame donates its type byte to the nibble.
    always_comb begin
        d_ext    = {{(EXT_W-TRANSCODER_WIDTH){1'b0}}, data_p1_q};
        mask     = data_p1_q[4:1];
        nib      = data_p1_q[8:5];
        dec_err  = ~data_p1_q[0] & ((mask == 4'hF) | (nib == 4'h0));
        pos      = data_p1_q[0] ? 9'd1 : 9'd9;
        seen_ctl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (data_p1_q[0] || mask[k]) begin
                dec_frame[k] = {2'b01, d_ext[pos +: 64]};
                pos          = pos + 9'd64;
            end else if (!seen_ctl) begin
                dec_frame[k] = {2'b10, d_ext[pos +: 56], restore_type(nib)};
                pos          = pos + 9'd56;
                seen_ctl     = 1'b1;
            end else begin
                dec_frame[k] = {2'b10, d_ext[pos +: 64]};
                pos          = pos + 9'd64;
            end
            if (dec_err) begin
                dec_frame[k] = ERR_FRAME;
            end
        end
    end

    always_comb begin
        vld_p2_d   = vld_p1_q;
        err_p2_d   = err_p2_q;
        frame_p2_d = frame_p2_q;
        if (vld_p1_q) begin
            err_p2_d   = dec_err;
            frame_p2_d = dec_frame;
        end
        cnt_d = cnt_q;
        if (bus.i_clr_count) begin
            cnt_d = '0;
        end else if (vld_p1_q && dec_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q     <= '0;
            primed_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            data_p1_q  <= '0;
            vld_p2_q   <= 1'b0;
            err_p2_q   <= 1'b0;
            frame_p2_q <= '{default: '0};
            cnt_q      <= '0;
        end else begin
            hist_q     <= hist_d;
            primed_q   <= primed_d;
            vld_p1_q   <= vld_p1_d;
            data_p1_q  <= data_p1_d;
            vld_p2_q   <= vld_p2_d;
            err_p2_q   <= err_p2_d;
            frame_p2_q <= frame_p2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_valid     = vld_p2_q;
    assign bus.o_block_err = err_p2_q;
    assign bus.o_frame_0   = frame_p2_q[0];
    assign bus.o_frame_1   = frame_p2_q[1];
    assign bus.o_frame_2   = frame_p2_q[2];
    assign bus.o_frame_3   = frame_p2_q[3];
    assign bus.o_err_count = cnt_q;
endmodule

// File: tb/tb_pcs_rx_decoder.sv
// Scoreboard bench: frames are encoded and scrambled here, expected frames
// queued at drive time and compared when the decoder presents them.
module tb_pcs_rx_decoder;
    localparam int TW = 257;
    localparam int FW = 66;

    typedef logic [3:0][65:0] frames_t;
    typedef struct packed {
        frames_t f;
        logic    err;
    } exp_t;

    localparam logic [65:0] ERR_FRAME = {2'b10, {8{7'h1E}}, 8'h1E};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pcs_rx_decoder_if #(.TRANSCODER_WIDTH(TW), .FRAME_WIDTH(FW), .COUNT_WIDTH(32)) bus ();
    pcs_rx_decoder_if #(.TRANSCODER_WIDTH(TW), .FRAME_WIDTH(FW), .COUNT_WIDTH(4))  bus4 ();

    assign bus4.i_valid     = bus.i_valid;
    assign bus4.i_data      = bus.i_data;
    assign bus4.i_clr_count = bus.i_clr_count;

    pcs_rx_decoder #(.TRANSCODER_WIDTH(TW), .FRAME_WIDTH(FW), .COUNT_WIDTH(32)) u_dut (
        .clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
    pcs_rx_decoder #(.TRANSCODER_WIDTH(TW), .FRAME_WIDTH(FW), .COUNT_WIDTH(4)) u_dut4 (
        .clk(clk), .i_rst_n(rst_n), .bus(bus4)
    );

    int          n_checks;
    int          n_errors;
    exp_t        sb[$];
    logic [57:0] tx_hist;
    bit          tb_primed;
    frames_t     last_f;
    logic        last_err;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    logic        clr_s;
    exp_t        mon_e;
    logic        mon_got_err;
    logic [7:0]  ttab [15] = '{8'hE1, 8'hD2, 8'h33, 8'hB4, 8'h55, 8'h66, 8'h87, 8'h78,
                              8'h99, 8'hAA, 8'h4B, 8'hCC, 8'h2D, 8'h1E, 8'hFF};

    task automatic check_val(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [256:0] rand_block();
        logic [287:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
        return tmp[256:0];
    endfunction

    function automatic logic [256:0] scramble(input logic [256:0] p, input logic [57:0] h);
        logic [314:0] ext;
        ext        = '0;
        ext[57:0]  = h;
        for (int i = 0; i < 257; i++) begin
            ext[58+i] = p[i] ^ ext[19+i] ^ ext[i];
        end
        return ext[314:58];
    endfunction

    function automatic logic [256:0] encode(input frames_t f);
        logic [256:0] p;
        logic [3:0]   m;
        logic [8:0]   pos;
        bit           seen;
        p    = '0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) m[k] = (f[k][65:64] == 2'b01);
        if (m == 4'hF) begin
            p[0] = 1'b1;
            pos  = 9'd1;
        end else begin
            p[4:1] = m;
            pos    = 9'd9;
        end
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                p[pos +: 64] = f[k][63:0];
                pos          = pos + 9'd64;
            end else if (!seen) begin
                p[8:5]       = f[k][3:0];
                p[pos +: 56] = f[k][63:8];
                pos          = pos + 9'd56;
                seen         = 1'b1;
            end else begin
                p[pos +: 64] = f[k][63:0];
                pos          = pos + 9'd64;
            end
        end
        return p;
    endfunction

    function automatic frames_t gen_frames(input logic [3:0] m, input logic [7:0] t);
        frames_t f;
        bit      seen;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                f[k] = {2'b01, $urandom, $urandom};
            end else if (!seen) begin
                f[k] = {2'b10, $urandom, 24'($urandom), t};
                seen = 1'b1;
            end else begin
                f[k] = {2'b10, $urandom, $urandom};
            end
        end
        return f;
    endfunction

    task automatic drive(input logic [256:0] data, input exp_t e);
        bus.i_data  = data;
        bus.i_valid = 1'b1;
        tx_hist     = data[256:199];
        if (!tb_primed) tb_primed = 1'b1;
        else sb.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_frames(input frames_t f);
        exp_t e;
        e.f   = f;
        e.err = 1'b0;
        drive(scramble(encode(f), tx_hist), e);
    endtask

    task automatic send_err(input logic [256:0] plain);
        exp_t e;
        e.f   = {4{ERR_FRAME}};
        e.err = 1'b1;
        drive(scramble(plain, tx_hist), e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"},  66'(bus.o_valid), 66'd0);
        check_val({tag, "_blkerr"}, 66'(bus.o_block_err), 66'd0);
        check_val({tag, "_frame0"}, 66'(bus.o_frame_0), 66'd0);
        check_val({tag, "_frame3"}, 66'(bus.o_frame_3), 66'd0);
        check_val({tag, "_count"},  66'(bus.o_err_count), 66'd0);
        check_val({tag, "_count4"}, 66'(bus4.o_err_count), 66'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        tx_hist   = '0;
        tb_primed = 1'b0;
        last_f    = '0;
        last_err  = 1'b0;
        exp_cnt   = '0;
        exp_cnt4  = '0;
    endtask

    always @(posedge clk) clr_s <= bus.i_clr_count;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_got_err = 1'b0;
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_valid", 66'(bus.o_valid), 66'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("frame0", bus.o_frame_0, mon_e.f[0]);
                    check_val("frame1", bus.o_frame_1, mon_e.f[1]);
                    check_val("frame2", bus.o_frame_2, mon_e.f[2]);
                    check_val("frame3", bus.o_frame_3, mon_e.f[3]);
                    check_val("block_err", 66'(bus.o_block_err), 66'(mon_e.err));
                    last_f      = mon_e.f;
                    last_err    = mon_e.err;
                    mon_got_err = mon_e.err;
                end
            end else begin
                check_val("hold_frame0", bus.o_frame_0, last_f[0]);
                check_val("hold_frame1", bus.o_frame_1, last_f[1]);
                check_val("hold_frame2", bus.o_frame_2, last_f[2]);
                check_val("hold_frame3", bus.o_frame_3, last_f[3]);
                check_val("hold_blkerr", 66'(bus.o_block_err), 66'(last_err));
            end
            if (clr_s) begin
                exp_cnt  = '0;
                exp_cnt4 = '0;
            end else if (mon_got_err) begin
                if (exp_cnt != '1) exp_cnt = exp_cnt + 32'd1;
                if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
            end
            check_val("err_count", 66'(bus.o_err_count), 66'(exp_cnt));
            check_val("err_count4", 66'(bus4.o_err_count), 66'(exp_cnt4));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frames_t      f;
        logic [256:0] p;
        logic [3:0]   m;
        n_checks        = 0;
        n_errors        = 0;
        bus.i_valid     = 1'b0;
        bus.i_data      = '0;
        bus.i_clr_count = 1'b0;
        rst_n           = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        idle(1);
        rst_n = 1'b1;

        // zero blocks: first primes, next two decode as invalid
        repeat (3) send_err('0);
        idle(4);
        check_val("zero_err_count", 66'(bus.o_err_count), 66'd2);

        // mask 0101: frames 0,2 data, frame 1 first control with type 0x78
        f = gen_frames(4'b0101, 8'h78);
        send_frames(f);
        idle(3);
        check_val("mask0101_f1_type", 66'(bus.o_frame_1[7:0]), 66'h78);
        check_val("mask0101_f3_hdr", 66'(bus.o_frame_3[65:64]), 66'd2);

        // random mix of data/control blocks with gaps between some of them
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom_range(0, 15));
            send_frames(gen_frames(m, ttab[$urandom_range(0, 14)]));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        send_frames(gen_frames(4'hF, 8'h00));
        send_frames(gen_frames(4'h0, 8'hFF));
        send_frames(gen_frames(4'hE, 8'hE1));

        // invalid encodings: mask all ones, and zero nibble
        p      = rand_block();
        p[0]   = 1'b0;
        p[4:1] = 4'hF;
        send_err(p);
        p      = rand_block();
        p[0]   = 1'b0;
        p[4:1] = 4'b0101;
        p[8:5] = 4'h0;
        send_err(p);
        send_frames(gen_frames(4'b1010, 8'h2D));
        idle(3);

        // saturation of the narrow counter
        repeat (20) send_err('0);
        idle(3);
        check_val("count4_saturated", 66'(bus4.o_err_count), 66'hF);

        // clear held across error arrivals wins
        bus.i_clr_count = 1'b1;
        send_err('0);
        send_err('0);
        idle(2);
        check_val("clr_with_err", 66'(bus4.o_err_count), 66'd0);
        bus.i_clr_count = 1'b0;
        send_err('0);
        idle(3);
        check_val("count_after_clr", 66'(bus.o_err_count), 66'd1);

        // reset with blocks in flight
        send_frames(gen_frames(4'b0011, 8'h55));
        send_frames(gen_frames(4'b1100, 8'h99));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        idle(2);
        rst_n = 1'b1;
        send_frames(gen_frames(4'b0110, 8'hCC));
        idle(4);
        for (int n = 0; n < 6; n++) begin
            send_frames(gen_frames(4'($urandom_range(0, 15)), ttab[$urandom_range(0, 14)]));
        end
        idle(6);
        check_val("sb_drained", 66'(sb.size()), 66'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
